// File: rtl/cr_seu_randclk_gen.sv
// ============================================================================
// cr_seu_randclk_gen : seedable LFSR driving the IU random-clock module-enable bus
// Revision: 1.0
// ============================================================================
`default_nettype none

module cr_seu_randclk_gen #(
    parameter logic [31:0] RST_SEED = 32'h0000_0001,
    parameter logic [31:0] TAPS     = 32'h8020_0003
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        randclk_ctrl_en,
    input  logic [1:0]  randclk_ctrl_density,
    input  logic [3:0]  randclk_ctrl_period,
    input  logic        randclk_seed_vld,
    input  logic [31:0] randclk_seed_data,
    input  logic        had_randclk_freeze,
    output logic [31:0] seu_iu_randclk_mod_en,
    output logic        randclk_gen_active
);

    logic [31:0] lfsr;
    logic [3:0]  cnt;
    logic [31:0] lfsr_next;
    logic [31:0] mask_next;
    logic [31:0] lfsr_rot;

    // Galois step; a non-zero value never maps to zero.
    assign lfsr_next = {1'b0, lfsr_next_src(lfsr)} ^ (lfsr[0] ? TAPS : 32'h0);

    function automatic logic [30:0] lfsr_next_src(input logic [31:0] l);
        return l[31:1];
    endfunction

    // Bit i of the rotated word is bit (i+16) mod 32 of the stepped LFSR.
    assign lfsr_rot = {lfsr_next[15:0], lfsr_next[31:16]};

    always_comb begin
        mask_next = lfsr_next;
        case (randclk_ctrl_density)
            2'b00:   mask_next = lfsr_next & lfsr_rot;
            2'b01:   mask_next = lfsr_next;
            2'b10:   mask_next = lfsr_next | lfsr_rot;
            default: mask_next = 32'hFFFF_FFFF;
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            lfsr                  <= RST_SEED;
            cnt                   <= 4'd0;
            seu_iu_randclk_mod_en <= 32'h0;
            randclk_gen_active    <= 1'b0;
        end else if (randclk_seed_vld) begin
            lfsr                  <= (randclk_seed_data == 32'h0) ? 32'h1 : randclk_seed_data;
            cnt                   <= 4'd0;
            seu_iu_randclk_mod_en <= 32'h0;
            randclk_gen_active    <= 1'b0;
        end else if (had_randclk_freeze) begin
            randclk_gen_active    <= 1'b0;
        end else if (!randclk_ctrl_en) begin
            cnt                   <= 4'd0;
            seu_iu_randclk_mod_en <= 32'h0;
            randclk_gen_active    <= 1'b0;
        end else if (cnt >= randclk_ctrl_period) begin
            lfsr                  <= lfsr_next;
            seu_iu_randclk_mod_en <= mask_next;
            cnt                   <= 4'd0;
            randclk_gen_active    <= 1'b1;
        end else begin
            cnt                   <= cnt + 4'd1;
            randclk_gen_active    <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cr_seu_randclk_gen.sv
// ============================================================================
// tb_cr_seu_randclk_gen : directed bench with hand-computed LFSR/mask values
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cr_seu_randclk_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  density;
    logic [3:0]  period;
    logic        seed_vld;
    logic [31:0] seed_data;
    logic        freeze;
    logic [31:0] mod_en;
    logic        active;

    int n_cmp;
    int n_mis;

    cr_seu_randclk_gen dut (
        .forever_cpuclk        (clk),
        .cpurst_b              (rst_n),
        .randclk_ctrl_en       (en),
        .randclk_ctrl_density  (density),
        .randclk_ctrl_period   (period),
        .randclk_seed_vld      (seed_vld),
        .randclk_seed_data     (seed_data),
        .had_randclk_freeze    (freeze),
        .seu_iu_randclk_mod_en (mod_en),
        .randclk_gen_active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic seed_write(input logic [31:0] d);
        seed_vld  = 1'b1;
        seed_data = d;
        tick();
        seed_vld  = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_mis     = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        density   = 2'b01;
        period    = 4'd0;
        seed_vld  = 1'b0;
        seed_data = 32'h0;
        freeze    = 1'b0;
        #12;
        check_val("reset_mod_en", mod_en, 32'h0);
        check_val("reset_active", {31'h0, active}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: seed 1, density 50%, period 0
        seed_write(32'h1);
        check_val("s1_seed_mod_en", mod_en, 32'h0);
        en = 1'b1;
        tick();
        check_val("s1_first", mod_en, 32'h8020_0003);
        check_val("s1_active", {31'h0, active}, 32'h1);
        tick();
        check_val("s1_second", mod_en, 32'hC030_0002);

        // Scenario 2: other densities on the first value
        seed_write(32'h1);
        check_val("s2_seed_clears", mod_en, 32'h0);
        check_val("s2_seed_active", {31'h0, active}, 32'h0);
        density = 2'b10;
        tick();
        check_val("s2_d75", mod_en, 32'h8023_8023);
        seed_write(32'h1);
        density = 2'b11;
        tick();
        check_val("s2_d100", mod_en, 32'hFFFF_FFFF);
        seed_write(32'h1);
        density = 2'b00;
        tick();
        check_val("s2_d25", mod_en, 32'h0);
        tick();
        // step(0x80200003)=0xC0300002; AND with rot16 0x0002C030 = 0
        check_val("s2_d25_second", mod_en, 32'h0);

        // Scenario 3: period 3 dwell, then period lowered mid-dwell
        density = 2'b01;
        period  = 4'd3;
        seed_write(32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("s3_dwell_hold", mod_en, 32'h0);
        end
        tick();
        check_val("s3_refresh", mod_en, 32'h8020_0003);
        tick();
        check_val("s3_hold_c1", mod_en, 32'h8020_0003);
        tick();
        check_val("s3_hold_c2", mod_en, 32'h8020_0003);
        period = 4'd0;
        tick();
        check_val("s3_period_drop", mod_en, 32'hC030_0002);

        // Scenario 4: zero seed under freeze
        freeze = 1'b1;
        seed_write(32'h0);
        check_val("s4_seed_mod_en", mod_en, 32'h0);
        check_val("s4_seed_active", {31'h0, active}, 32'h0);
        tick();
        check_val("s4_frozen_hold", mod_en, 32'h0);
        freeze = 1'b0;
        tick();
        check_val("s4_restart", mod_en, 32'h8020_0003);
        check_val("s4_active", {31'h0, active}, 32'h1);
        tick();
        check_val("s4_second", mod_en, 32'hC030_0002);

        // Scenario 5: freeze for 10 cycles, resume, then disable
        freeze = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("s5_freeze_mod_en", mod_en, 32'hC030_0002);
            check_val("s5_freeze_active", {31'h0, active}, 32'h0);
        end
        freeze = 1'b0;
        tick();
        check_val("s5_resume", mod_en, 32'h6018_0001);
        en = 1'b0;
        tick();
        check_val("s5_disable", mod_en, 32'h0);
        check_val("s5_disable_active", {31'h0, active}, 32'h0);
        tick();
        en = 1'b1;
        tick();
        // LFSR held while disabled: step(0x60180001)
        check_val("s5_reenable", mod_en, 32'hB02C_0003);

        // Scenario 6: asynchronous reset mid-dwell
        period = 4'd3;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("s6_async_mod_en", mod_en, 32'h0);
        check_val("s6_async_active", {31'h0, active}, 32'h0);
        @(negedge clk);
        period = 4'd0;
        rst_n  = 1'b1;
        tick();
        check_val("s6_after_reset", mod_en, 32'h8020_0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
